// File: rtl/clint_timer_pkg.sv
// Types and helpers shared by clint_timer and clint_mtime_cnt:
// register-select enum, the mtime write-port struct, offset decode and
// byte-masked word merge.
`include "clint_defines.sv"

package clint_timer_pkg;

  localparam logic [15:0] MSIP_OFS   = `CLINT_MSIP_OFS;
  localparam logic [15:0] CMP_LO_OFS = `CLINT_MTIMECMP_LO_OFS;
  localparam logic [15:0] CMP_HI_OFS = `CLINT_MTIMECMP_HI_OFS;
  localparam logic [15:0] MT_LO_OFS  = `CLINT_MTIME_LO_OFS;
  localparam logic [15:0] MT_HI_OFS  = `CLINT_MTIME_HI_OFS;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_MT_LO, SEL_MT_HI
  } reg_sel_e;

  // Write port into the mtime counter: one half selected per cycle.
  typedef struct packed {
    logic        we_lo;
    logic        we_hi;
    logic [31:0] data;
    logic [3:0]  mask;
  } mtime_wr_t;

  function automatic reg_sel_e decode_ofs(input logic [15:0] ofs);
    reg_sel_e sel;
    case (ofs)
      MSIP_OFS:   sel = SEL_MSIP;
      CMP_LO_OFS: sel = SEL_CMP_LO;
      CMP_HI_OFS: sel = SEL_CMP_HI;
      MT_LO_OFS:  sel = SEL_MT_LO;
      MT_HI_OFS:  sel = SEL_MT_HI;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/clint_defines.sv
// Shared address-map macros for the core-local interruptor.
// Offsets are addr[15:0] within the CLINT region; CLINT_BASE is the
// default region base (only bits 31:16 take part in the region match).
`ifndef CLINT_DEFINES_SV
`define CLINT_DEFINES_SV

`define CLINT_BASE            32'h0200_0000
`define CLINT_MSIP_OFS        16'h0000
`define CLINT_MTIMECMP_LO_OFS 16'h4000
`define CLINT_MTIMECMP_HI_OFS 16'h4004
`define CLINT_MTIME_LO_OFS    16'hBFF8
`define CLINT_MTIME_HI_OFS    16'hBFFC

`endif

// File: rtl/clint_mtime_cnt.sv
// 64-bit mtime counter with prescaler and byte-masked write port.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   wr          write request into either half (struct, see package)
//   mtime       current counter value
// A write cycle with any byte enabled takes priority over the tick: the
// increment is dropped and the unwritten bytes keep their old value.
// The prescaler never stops.
import clint_timer_pkg::*;

module clint_mtime_cnt #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  mtime_wr_t   wr,
  output logic [63:0] mtime
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [15:0] presc;
  logic        tick;
  logic        wr_any;

  assign tick   = (presc == PRESC_MAX);
  assign wr_any = (wr.we_lo | wr.we_hi) & (|wr.mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      mtime <= '0;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (wr_any) begin
        if (wr.we_lo) mtime[31:0]  <= byte_merge(mtime[31:0],  wr.data, wr.mask);
        if (wr.we_hi) mtime[63:32] <= byte_merge(mtime[63:32], wr.data, wr.mask);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: msip, mtimecmp, mtime and interrupt outputs,
// accessed over the LSU req/load/store/res handshake.
// Ports:
//   req/load/store/addr/store_result/store_mask _from_lsu  request side
//   res_to_lsu, data_to_lsu   one-cycle response, fixed latency 1
//   soft_irq                  msip bit
//   time_irq                  registered (mtime >= mtimecmp)
// Every request gets a response; only a single-qualifier, in-region,
// aligned, mapped access has any effect or returns nonzero data.
`include "clint_defines.sv"
import clint_timer_pkg::*;

module clint_timer #(
  parameter logic [31:0] BASE_ADDR = `CLINT_BASE,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_from_lsu,
  input  logic        load_from_lsu,
  input  logic        store_from_lsu,
  input  logic [31:0] addr_from_lsu,
  input  logic [31:0] store_result_from_lsu,
  input  logic [3:0]  store_mask_from_lsu,
  output logic        res_to_lsu,
  output logic [31:0] data_to_lsu,
  output logic        soft_irq,
  output logic        time_irq
);

  logic        single, region_hit, aligned, wr, rd;
  reg_sel_e    sel;
  logic        msip;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;
  logic [31:0] rdata;
  mtime_wr_t   mt_wr;

  assign single     = req_from_lsu & (load_from_lsu ^ store_from_lsu);
  assign region_hit = (addr_from_lsu[31:16] == BASE_ADDR[31:16]);
  assign aligned    = (addr_from_lsu[1:0] == 2'b00);
  assign sel        = (single & region_hit & aligned) ? decode_ofs(addr_from_lsu[15:0])
                                                      : SEL_NONE;
  assign wr         = store_from_lsu & (sel != SEL_NONE);
  assign rd         = load_from_lsu  & (sel != SEL_NONE);

  assign mt_wr.we_lo = wr & (sel == SEL_MT_LO);
  assign mt_wr.we_hi = wr & (sel == SEL_MT_HI);
  assign mt_wr.data  = store_result_from_lsu;
  assign mt_wr.mask  = store_mask_from_lsu;

  clint_mtime_cnt #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (mt_wr),
    .mtime (mtime)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MSIP:   rdata = {31'b0, msip};
      SEL_CMP_LO: rdata = mtimecmp[31:0];
      SEL_CMP_HI: rdata = mtimecmp[63:32];
      SEL_MT_LO:  rdata = mtime[31:0];
      SEL_MT_HI:  rdata = mtime[63:32];
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip        <= 1'b0;
      mtimecmp    <= '1;
      res_to_lsu  <= 1'b0;
      data_to_lsu <= '0;
      time_irq    <= 1'b0;
    end else begin
      res_to_lsu  <= req_from_lsu;
      data_to_lsu <= rd ? rdata : 32'd0;
      // Compare uses the registered values, so any write shows up here
      // one cycle after it lands.
      time_irq    <= (mtime >= mtimecmp);
      if (wr && sel == SEL_MSIP && store_mask_from_lsu[0])
        msip <= store_result_from_lsu[0];
      if (wr && sel == SEL_CMP_LO)
        mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0],  store_result_from_lsu, store_mask_from_lsu);
      if (wr && sel == SEL_CMP_HI)
        mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], store_result_from_lsu, store_mask_from_lsu);
    end
  end

  assign soft_irq = msip;

endmodule
